param_modcount: RTL and testbench

Parametrised modulo up/down counter. It is the next-generation replacement for the fixed-width up/down counter. It adds programmable modulus, variable step, parallel load, count enable, a wrap/saturate mode and terminal/overflow flags. It is used as a general event/timer counter inside datapath and control blocks.

---
 rtl/param_modcount.sv | 96 +++++++++
 tb/tb_param_modcount.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/param_modcount.sv
// Modulo up/down counter with programmable modulus, variable step, parallel load and
// wrap/saturate behaviour. Flags the terminal values and pulses on bound crossings.
module param_modcount #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             UorD,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : gen_bad_modulus
    $error("param_modcount: MODULUS must lie in 2..2**WIDTH");
  end

  // Bound arithmetic is done one bit wider so MODULUS = 2**WIDTH is representable.
  localparam logic [WIDTH:0]   ModW = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0]   MaxW = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH:0] sum_up;
  logic [WIDTH:0] wrap_up;
  logic [WIDTH:0] wrap_dn;

  always_comb begin
    sum_up  = {1'b0, count_q} + {1'b0, step};
    wrap_up = sum_up - ModW;
    wrap_dn = {1'b0, count_q} + ModW - {1'b0, step};

    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;

    if (load) begin
      count_d = ({1'b0, load_val} > MaxW) ? MaxV : load_val;
    end else if (en) begin
      if (UorD) begin
        if (sum_up > MaxW) begin
          ovf_d = 1'b1;
          // An out-of-range step may still leave the wrapped value too large; clamp it.
          if (SATURATE || (wrap_up > MaxW)) begin
            count_d = MaxV;
          end else begin
            count_d = wrap_up[WIDTH-1:0];
          end
        end else begin
          count_d = sum_up[WIDTH-1:0];
        end
      end else begin
        if (step > count_q) begin
          unf_d = 1'b1;
          if (SATURATE || (wrap_dn > MaxW)) begin
            count_d = '0;
          end else begin
            count_d = wrap_dn[WIDTH-1:0];
          end
        end else begin
          count_d = count_q - step;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count  = count_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign at_max = (count_q == MaxV);
  assign at_min = (count_q == '0);

endmodule

// File: tb/tb_param_modcount.sv
// Scoreboard bench for param_modcount: three instances (wrap/10, saturate/10, wrap/16)
// share stimulus; an integer reference model queues expectations for a separate monitor.
module tb_param_modcount;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       UorD;
  logic       load;
  logic [3:0] step;
  logic [3:0] load_val;

  logic [3:0] cnt  [3];
  logic       amax [3];
  logic       amin [3];
  logic       ovf  [3];
  logic       unf  [3];

  int checks = 0;
  int errors = 0;

  int mods [3] = '{10, 10, 16};
  bit sats [3] = '{1'b0, 1'b1, 1'b0};
  int mc   [3];
  int mo   [3];
  int mu   [3];

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  always #5 clk = ~clk;

  param_modcount #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap10 (
    .clk(clk), .rst(rst), .en(en), .UorD(UorD), .step(step), .load(load),
    .load_val(load_val), .count(cnt[0]), .at_max(amax[0]), .at_min(amin[0]),
    .ovf(ovf[0]), .unf(unf[0])
  );

  param_modcount #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat10 (
    .clk(clk), .rst(rst), .en(en), .UorD(UorD), .step(step), .load(load),
    .load_val(load_val), .count(cnt[1]), .at_max(amax[1]), .at_min(amin[1]),
    .ovf(ovf[1]), .unf(unf[1])
  );

  param_modcount #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_wrap16 (
    .clk(clk), .rst(rst), .en(en), .UorD(UorD), .step(step), .load(load),
    .load_val(load_val), .count(cnt[2]), .at_max(amax[2]), .at_min(amin[2]),
    .ovf(ovf[2]), .unf(unf[2])
  );

  task automatic chk(input string name, input int i, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %0d, expected %0d", name, i, $time, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the counting rules.
  task automatic model_step(input int i, input bit r, input bit ld, input int lv,
                            input bit e, input bit ud, input int st);
    int m;
    int s;
    m = mods[i];
    if (!r) begin
      mc[i] = 0; mo[i] = 0; mu[i] = 0;
    end else if (ld) begin
      mc[i] = (lv < m) ? lv : m - 1;
      mo[i] = 0; mu[i] = 0;
    end else if (e && ud) begin
      s = mc[i] + st;
      mu[i] = 0;
      if (s < m) begin
        mc[i] = s; mo[i] = 0;
      end else begin
        mc[i] = sats[i] ? m - 1 : s - m;
        mo[i] = 1;
      end
    end else if (e) begin
      mo[i] = 0;
      if (st <= mc[i]) begin
        mc[i] = mc[i] - st; mu[i] = 0;
      end else begin
        mc[i] = sats[i] ? 0 : mc[i] + m - st;
        mu[i] = 1;
      end
    end else begin
      mo[i] = 0; mu[i] = 0;
    end
  endtask

  function automatic logic [7:0] pack_exp(input int i);
    logic [3:0] c;
    c = 4'(mc[i]);
    return {c, mo[i] != 0, mu[i] != 0, mc[i] == mods[i] - 1, mc[i] == 0};
  endfunction

  // Apply one cycle of inputs at the falling edge and queue the post-edge expectation.
  task automatic drive(input bit r, input bit ld, input int lv, input bit e, input bit ud,
                       input int st);
    @(negedge clk);
    rst = r; load = ld; load_val = 4'(lv); en = e; UorD = ud; step = 4'(st);
    for (int i = 0; i < 3; i++) begin
      model_step(i, r, ld, lv, e, ud, st);
      case (i)
        0: q0.push_back(pack_exp(i));
        1: q1.push_back(pack_exp(i));
        default: q2.push_back(pack_exp(i));
      endcase
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_count"}, i, int'(cnt[i]), 0);
      chk({tag, "_ovf"}, i, int'(ovf[i]), 0);
      chk({tag, "_unf"}, i, int'(unf[i]), 0);
      chk({tag, "_at_min"}, i, int'(amin[i]), 1);
      chk({tag, "_at_max"}, i, int'(amax[i]), 0);
    end
  endtask

  // Monitor: outputs settle one step after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        logic [7:0] ex;
        bit         have;
        have = 1'b0;
        ex   = '0;
        case (i)
          0: if (q0.size() > 0) begin ex = q0.pop_front(); have = 1'b1; end
          1: if (q1.size() > 0) begin ex = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin ex = q2.pop_front(); have = 1'b1; end
        endcase
        if (have) begin
          chk("count", i, int'(cnt[i]), int'(ex[7:4]));
          chk("ovf", i, int'(ovf[i]), int'(ex[3]));
          chk("unf", i, int'(unf[i]), int'(ex[2]));
          chk("at_max", i, int'(amax[i]), int'(ex[1]));
          chk("at_min", i, int'(amin[i]), int'(ex[0]));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      mc[i] = 0; mo[i] = 0; mu[i] = 0;
    end
    rst = 1'b1; en = 1'b0; UorD = 1'b0; load = 1'b0; step = '0; load_val = '0;
    #1 rst = 1'b0;
    #1 chk_reset("reset");

    // Up count from reset through the wrap.
    repeat (10) drive(1, 0, 0, 1, 1, 1);
    // Down wrap with step 3.
    drive(1, 1, 1, 0, 0, 0);
    repeat (4) drive(1, 0, 0, 1, 0, 3);
    // Saturate-style sequence: push past the top twice, then below zero.
    drive(1, 1, 8, 0, 0, 0);
    repeat (2) drive(1, 0, 0, 1, 1, 3);
    drive(1, 1, 2, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 4);
    // Load wins over enable and clamps.
    drive(1, 1, 12, 1, 1, 1);
    drive(1, 1, 4, 0, 0, 0);
    // Hold cases.
    repeat (5) drive(1, 0, 0, 0, 1, 3);
    drive(1, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 1, 0, 0);

    // Async reset during an ovf pulse.
    drive(1, 1, 8, 0, 0, 0);
    repeat (2) drive(1, 0, 0, 1, 1, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_reset("async_rst_a");
    drive(0, 0, 0, 1, 1, 1);
    // Full-range wrap 15 -> 0, then reset mid-pulse.
    drive(1, 1, 15, 0, 0, 0);
    drive(1, 0, 0, 1, 1, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_reset("async_rst_b");
    drive(0, 0, 0, 0, 0, 0);

    // Randomised traffic, steps kept below the smallest modulus.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 15),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9));
    end

    repeat (2) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
